barcode_rx: RTL
===============

BARCODE_RX -- requirements
Module: barcode_rx

Interface
REQ-001 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-003 SHALL have port BC, input, 1, raw serial barcode line, asynchronous to clk, idle high.
REQ-004 SHALL have port clr_ID_vld, input, 1, consumer acknowledge; clears ID_vld.
REQ-005 SHALL have port ID, output, 8, last accepted station ID.
REQ-006 SHALL have port ID_vld, output, 1, a new ID is held and not yet acknowledged.

Function
REQ-007 SHALL double-flop BC before use (BC_s); falling edge = BC_s previous 1, current 0.
REQ-008 Frame format SHALL be: one start bit, then 8 data bits, MSB first; every bit begins with a falling edge.
REQ-009 Start-bit low time SHALL be measured in clk cycles into a 22-bit period register.
- The counter saturates at 22'h3FFFFF.
REQ-010 Data bit value SHALL be BC_s sampled exactly period cycles after that bit's falling edge.
REQ-011 FSM states SHALL be IDLE, MEAS, WAIT_FALL, SAMPLE.
- IDLE->MEAS on falling edge; counter cleared.
- MEAS: count while BC_s=0; ->WAIT_FALL on BC_s=1, latching period.
- WAIT_FALL->SAMPLE on falling edge; counter cleared.
- SAMPLE: when counter==period, shift BC_s into shift register LSB and increment bit count (0..8).
- From SAMPLE, ->WAIT_FALL while bit count<8, else ->IDLE.
REQ-012 On the 8th sample the frame SHALL be checked: if shift[7:6]==2'b00, ID<=shift and ID_vld<=1 on the next clk edge; otherwise the frame is discarded, with ID and ID_vld unchanged.
REQ-013 Valid frame while ID_vld=1 SHALL overwrite ID and keep ID_vld=1.
REQ-014 clr_ID_vld=1 SHALL clear ID_vld next edge; simultaneous set and clear: set wins.
REQ-015 Falling edges seen while in SAMPLE SHALL be ignored.
REQ-016 Bit count and shift register SHALL clear on every IDLE->MEAS transition.

Reset
REQ-017 rst_n low SHALL immediately force: FSM=IDLE, ID=8'h00, ID_vld=0, period=0, counter=0, bit count=0, shift=0, both sync flops=1.
REQ-018 Reset mid-frame SHALL discard the partial frame; no ID_vld pulse follows release.

Configuration
REQ-019 With BARCODE_TIMEOUT_EN defined: in WAIT_FALL, if no falling edge arrives within 4*period cycles, the FSM SHALL return to IDLE and discard the frame.
- 4*period is computed in 24 bits.
REQ-020 Without BARCODE_TIMEOUT_EN, WAIT_FALL SHALL wait indefinitely; no timeout logic is present.

Structure
REQ-021 Shared package SHALL hold: the FSM state enum, PERIOD_W=22, ID_W=8, NUM_BITS=8, VALID_PREFIX=2'b00.
REQ-022 Synchronizer plus falling-edge detector SHALL be one sub-module, bc_sync_edge; all else is in barcode_rx.

Verification
REQ-023 Period 100 cycles, data 8'h25 -> ID=8'h25, ID_vld=1 one cycle after the 8th sample.
REQ-024 Period 100, data 8'hC5 -> ID_vld stays 0, ID unchanged (8'h00 after reset).
REQ-025 After ID=8'h25 valid, drive clr_ID_vld 1 cycle -> ID_vld=0 next edge, ID still 8'h25.
- Repeat with clr_ID_vld asserted on the same edge a new 8'h12 frame completes -> ID=8'h12, ID_vld=1.
REQ-026 Assert rst_n=0 after the 4th data bit of 8'h25, then send 8'h0A -> ID=8'h0A, ID_vld=1; no ID_vld pulse in between.
REQ-027 BARCODE_TIMEOUT_EN, period 50, BC held high after 3 data bits for 250 cycles -> FSM in IDLE by cycle 201, ID_vld=0.
- Then send 8'h3F -> ID=8'h3F, ID_vld=1.

Source files
------------

// File: rtl/barcode_rx_pkg.sv
// Shared types and constants for the barcode receiver.
package barcode_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEAS,
    WAIT_FALL,
    SAMPLE
  } state_t;

  localparam int PERIOD_W  = 22;
  localparam int ID_W      = 8;
  localparam int NUM_BITS  = 8;
  localparam int BIT_CNT_W = 4;

  localparam logic [1:0]          VALID_PREFIX = 2'b00;
  localparam logic [PERIOD_W-1:0] PERIOD_MAX   = {PERIOD_W{1'b1}};

endpackage

// File: rtl/bc_sync_edge.sv
// Two-flop synchronizer for the raw barcode line plus a falling-edge detector.
module bc_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic bc,
  output logic bc_s,
  output logic fall
);

  logic meta;
  logic prev;

  // Line idles high, so every flop resets to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      bc_s <= 1'b1;
      prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make the three flops shift in lockstep.
      meta <= bc;
      bc_s <= meta;
      prev <= bc_s;
    end
  end

  assign fall = prev & ~bc_s;

endmodule

// File: rtl/barcode_rx.sv
// Serial barcode receiver: measures the start-bit period, then samples 8 data bits MSB first.
// Define BARCODE_TIMEOUT_EN to abandon a frame when WAIT_FALL exceeds 4*period cycles.
module barcode_rx
  import barcode_rx_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            BC,
  input  logic            clr_ID_vld,
  output logic [ID_W-1:0] ID,
  output logic            ID_vld
);

  logic bc_s;
  logic fall;

  bc_sync_edge u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .bc    (BC),
    .bc_s  (bc_s),
    .fall  (fall)
  );

  state_t                 state, state_nxt;
  logic [PERIOD_W-1:0]    cnt;
  logic [PERIOD_W-1:0]    period;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [ID_W-1:0]        shift;
  logic                   frame_done;

  logic [PERIOD_W-1:0]    cnt_inc;
  logic                   cnt_hit;
  logic                   last_bit;

  assign cnt_inc  = (cnt == PERIOD_MAX) ? cnt : cnt + 1'b1;
  assign cnt_hit  = (cnt == period);
  assign last_bit = (bit_cnt == BIT_CNT_W'(NUM_BITS - 1));

`ifdef BARCODE_TIMEOUT_EN
  logic [PERIOD_W+1:0] timeout_lim;
  logic                timed_out;
  assign timeout_lim = {period, 2'b00};
  assign timed_out   = ({2'b00, cnt} >= timeout_lim);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:      if (fall) state_nxt = MEAS;
      MEAS:      if (bc_s) state_nxt = WAIT_FALL;
      WAIT_FALL: begin
        if (fall) state_nxt = SAMPLE;
`ifdef BARCODE_TIMEOUT_EN
        else if (timed_out) state_nxt = IDLE;
`endif
      end
      SAMPLE:    if (cnt_hit) state_nxt = last_bit ? IDLE : WAIT_FALL;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      period     <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: if (fall) begin
          cnt     <= '0;
          bit_cnt <= '0;
          shift   <= '0;
        end
        MEAS: begin
          if (!bc_s) cnt <= cnt_inc;
          else begin
            period <= cnt;
            cnt    <= '0;
          end
        end
        WAIT_FALL: begin
          if (fall) cnt <= '0;
`ifdef BARCODE_TIMEOUT_EN
          else      cnt <= cnt_inc;
`endif
        end
        SAMPLE: begin
          // Falls arriving here are ignored; only the counter matters.
          if (cnt_hit) begin
            shift      <= {shift[ID_W-2:0], bc_s};
            bit_cnt    <= bit_cnt + 1'b1;
            cnt        <= '0;
            frame_done <= last_bit;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // The frame is judged one edge after the 8th sample; a valid set beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ID     <= '0;
      ID_vld <= 1'b0;
    end else if (frame_done && (shift[ID_W-1:ID_W-2] == VALID_PREFIX)) begin
      ID     <= shift;
      ID_vld <= 1'b1;
    end else if (clr_ID_vld) begin
      ID_vld <= 1'b0;
    end
  end

endmodule
